// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the Fetch stage
// (instruction reads) and the Memory stage (data loads/stores). One
// transaction is outstanding at a time. A three-state FSM (IDLE, BUSY_I,
// BUSY_D) sequences the memory handshake. The completion (rvalid + rdata) is
// returned to the requester that owns the transaction.
//
// Arbitration:
//   - Default build: data requests have fixed priority over instruction
//     requests.
//   - Define ARB_RR_EN for round-robin. On simultaneous requests, the
//     requester that did not own the previous transaction wins.
//
// Parameters:
//   AW      address width
//   DW      data width (byte enables are DW/8 bits)
//   TIMEOUT max cycles mem_req waits for mem_ack before aborting with bus_err
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   if_*             fetch request/grant/response (read only)
//   dm_*             data request/grant/response (load/store)
//   mem_*            memory-side handshake, held until mem_ack
//   bus_err          pulses together with the rvalid of a timed-out access
//   stall_if/_mem    per-stage stall requests to the hazard unit
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  // fetch port
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // data port
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,
  // memory port
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  // status
  output logic            bus_err,
  output logic            stall_if,
  output logic            stall_mem
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   be_q, be_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            if_pending_q, if_pending_d;
  logic            dm_pending_q, dm_pending_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            dm_rvalid_q, dm_rvalid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  logic            bus_err_q, bus_err_d;

  logic            if_gnt_c, dm_gnt_c;
  logic            pick_dm;
  logic            expired;
  logic [DW-1:0]   resp_data;

`ifdef ARB_RR_EN
  // 1 = data port owned the previous transaction.
  logic            last_dm_q, last_dm_d;
  assign pick_dm = dm_req & (~if_req | ~last_dm_q);
`else
  assign pick_dm = dm_req;
`endif

  // The count reaches TIMEOUT in the cycle the TIMEOUT-th unacked wait occurs.
  assign expired = ~mem_ack & (cnt_q == CW'(TIMEOUT - 1));

  // Stores and timed-out accesses return zero data.
  assign resp_data = (we_q | ~mem_ack) ? '0 : mem_rdata;

  // NOTE: every variable gets a default before the case statement. A path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    cnt_d        = cnt_q;
    if_pending_d = if_pending_q;
    dm_pending_d = dm_pending_q;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    bus_err_d    = 1'b0;
    if_gnt_c     = 1'b0;
    dm_gnt_c     = 1'b0;
`ifdef ARB_RR_EN
    last_dm_d    = last_dm_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_dm) begin
          dm_gnt_c     = 1'b1;
          addr_d       = dm_addr;
          we_d         = dm_we;
          wdata_d      = dm_wdata;
          be_d         = dm_be;
          cnt_d        = '0;
          dm_pending_d = 1'b1;
          state_d      = BUSY_D;
`ifdef ARB_RR_EN
          last_dm_d    = 1'b1;
`endif
        end else if (if_req) begin
          if_gnt_c     = 1'b1;
          addr_d       = if_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
          be_d         = '1;   // fetches always read the full word
          cnt_d        = '0;
          if_pending_d = 1'b1;
          state_d      = BUSY_I;
`ifdef ARB_RR_EN
          last_dm_d    = 1'b0;
`endif
        end
      end

      BUSY_I, BUSY_D: begin
        if (mem_ack || expired) begin
          state_d   = IDLE;
          bus_err_d = ~mem_ack;   // an ack in the expiry cycle wins
          if (state_q == BUSY_I) begin
            if_rvalid_d  = 1'b1;
            if_rdata_d   = resp_data;
            if_pending_d = 1'b0;
          end else begin
            dm_rvalid_d  = 1'b1;
            dm_rdata_d   = resp_data;
            dm_pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. This way every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      cnt_q        <= '0;
      if_pending_q <= 1'b0;
      dm_pending_q <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      bus_err_q    <= 1'b0;
`ifdef ARB_RR_EN
      last_dm_q    <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      cnt_q        <= cnt_d;
      if_pending_q <= if_pending_d;
      dm_pending_q <= dm_pending_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      bus_err_q    <= bus_err_d;
`ifdef ARB_RR_EN
      last_dm_q    <= last_dm_d;
`endif
    end
  end

  // The memory payload is only driven while a transaction is in flight. This
  // makes mem_* read zero in IDLE and drop straight away when reset asserts.
  logic busy;
  assign busy      = (state_q != IDLE);
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = busy ? addr_q  : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign mem_be    = busy ? be_q    : '0;

  // Grants and stalls are combinational. They are gated by reset so that
  // they are also zero while reset is held.
  assign if_gnt    = reset & if_gnt_c;
  assign dm_gnt    = reset & dm_gnt_c;
  assign stall_if  = reset & ((if_req & ~if_gnt_c) | if_pending_q);
  assign stall_mem = reset & ((dm_req & ~dm_gnt_c) | dm_pending_q);

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed test of mem_port_arbiter. Stimulus pushes the expected response
// (data, error flag, arrival cycle) into per-port queues. A monitor pops and
// compares whenever if_rvalid or dm_rvalid appears. A behavioural memory acks
// after a programmable number of wait cycles, or never.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;
  localparam int NEVER = 999;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt, if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            dm_req, dm_we;
  logic [AW-1:0]   dm_addr;
  logic [DW-1:0]   dm_wdata;
  logic [DW/8-1:0] dm_be;
  logic            dm_gnt, dm_rvalid;
  logic [DW-1:0]   dm_rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;
  logic            bus_err, stall_if, stall_mem;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_model [logic [31:0]];
  int          ack_wait = 0;
  int          wait_cnt = 0;

  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt == ack_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
      end
      wait_cnt++;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hA5A5_A5A5;
      wait_cnt  = 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t if_q[$];
  exp_t dm_q[$];
  exp_t if_e, dm_e;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (if_rvalid === 1'b1) begin
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_unexpected_rvalid: got rvalid expected none (cycle %0d)", cyc);
        end else begin
          if_e = if_q.pop_front();
          check("if_rdata", if_rdata, if_e.rdata);
          check("if_bus_err", bus_err, if_e.err);
          check("if_rvalid_cycle", cyc, if_e.cyc);
        end
      end
      if (dm_rvalid === 1'b1) begin
        if (dm_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dm_unexpected_rvalid: got rvalid expected none (cycle %0d)", cyc);
        end else begin
          dm_e = dm_q.pop_front();
          check("dm_rdata", dm_rdata, dm_e.rdata);
          check("dm_bus_err", bus_err, dm_e.err);
          check("dm_rvalid_cycle", cyc, dm_e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((if_q.size() != 0 || dm_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_outstanding", if_q.size() + dm_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int n0;
  bit d_first;

  initial begin
    reset    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_be    = '0;
    mem_ack  = 1'b0;
    mem_rdata = '0;
    mem_model[32'h0000_0010] = 32'h0050_0093;
    mem_model[32'h0000_0024] = 32'h0001_2345;
    mem_model[32'h0000_0100] = 32'h1234_5678;
    mem_model[32'h0000_0200] = 32'hCAFE_F00D;
    mem_model[32'h0000_0300] = 32'h7777_7777;
`ifdef ARB_RR_EN
    d_first = 1'b0;
`else
    d_first = 1'b1;
`endif

    // Reset state, with a request present so that a grant would show.
    tick(); tick();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_stall_if", stall_if, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_dm_rvalid", dm_rvalid, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_if_rdata", if_rdata, 0);
    tick();
    if_req = 1'b0;
    reset = 1'b1;

    // Single fetch, ack two cycles after mem_req rises.
    tick();
    if_req = 1'b1; if_addr = 32'h10; ack_wait = 2; n0 = cyc;
    #1;
    check("f_if_gnt", if_gnt, 1);
    check("f_dm_gnt", dm_gnt, 0);
    check("f_stall_if_c0", stall_if, 0);
    if_q.push_back('{32'h0050_0093, 1'b0, n0 + 4});
    tick();
    if_req = 1'b0;
    #1;
    check("f_mem_req_c1", mem_req, 1);
    check("f_mem_addr", mem_addr, 32'h10);
    check("f_mem_we", mem_we, 0);
    check("f_stall_if_c1", stall_if, 1);
    tick(); #1;
    check("f_mem_req_c2", mem_req, 1);
    tick(); #1;
    check("f_mem_req_c3", mem_req, 1);
    check("f_stall_if_c3", stall_if, 1);
    tick(); #1;
    check("f_mem_req_c4", mem_req, 0);
    check("f_stall_if_c4", stall_if, 0);
    drain(5);

    // Store with zero-wait ack. The memory returns data that must be dropped.
    tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    dm_be = 4'hF; ack_wait = 0; n0 = cyc;
    #1;
    check("s_dm_gnt", dm_gnt, 1);
    check("s_stall_mem_c0", stall_mem, 0);
    dm_q.push_back('{32'h0, 1'b0, n0 + 2});
    tick();
    dm_req = 1'b0; dm_we = 1'b0;
    #1;
    check("s_mem_req", mem_req, 1);
    check("s_mem_we", mem_we, 1);
    check("s_mem_be", mem_be, 4'hF);
    check("s_mem_addr", mem_addr, 32'h100);
    check("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("s_stall_mem_c1", stall_mem, 1);
    tick(); #1;
    check("s_mem_we_after", mem_we, 0);
    check("s_mem_req_after", mem_req, 0);
    check("s_stall_mem_c2", stall_mem, 0);
    drain(5);

    // Load with one wait cycle. A fetch arriving while busy waits in place.
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_be = 4'h3; ack_wait = 1; n0 = cyc;
    #1;
    check("l_dm_gnt", dm_gnt, 1);
    dm_q.push_back('{32'hCAFE_F00D, 1'b0, n0 + 3});
    tick();
    dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h24;
    #1;
    check("l_if_gnt_busy1", if_gnt, 0);
    check("l_stall_if_busy1", stall_if, 1);
    tick(); #1;
    check("l_if_gnt_busy2", if_gnt, 0);
    tick(); #1;
    check("l_if_gnt_idle", if_gnt, 1);
    if_q.push_back('{32'h0001_2345, 1'b0, n0 + 6});
    tick();
    if_req = 1'b0;
    drain(10);

    // Timeout: the memory never acks.
    tick();
    dm_req = 1'b1; dm_addr = 32'h300; ack_wait = NEVER; n0 = cyc;
    #1;
    check("t_dm_gnt", dm_gnt, 1);
    dm_q.push_back('{32'h0, 1'b1, n0 + TIMEOUT + 1});
    tick();
    dm_req = 1'b0;
    repeat (TIMEOUT - 1) tick();
    #1;
    check("t_mem_req_last", mem_req, 1);
    check("t_stall_mem_last", stall_mem, 1);
    tick();
    if_req = 1'b1; if_addr = 32'h10; ack_wait = 0;
    #1;
    check("t_mem_req_drop", mem_req, 0);
    check("t_stall_mem_drop", stall_mem, 0);
    check("t_next_if_gnt", if_gnt, 1);
    if_q.push_back('{32'h0050_0093, 1'b0, n0 + TIMEOUT + 3});
    tick();
    if_req = 1'b0;
    drain(10);

    // An ack in the cycle the count reaches TIMEOUT is a normal completion.
    tick();
    dm_req = 1'b1; dm_addr = 32'h200; ack_wait = TIMEOUT - 1; n0 = cyc;
    #1;
    check("b_dm_gnt", dm_gnt, 1);
    dm_q.push_back('{32'hCAFE_F00D, 1'b0, n0 + TIMEOUT + 1});
    tick();
    dm_req = 1'b0;
    drain(TIMEOUT + 10);

    // Contention after a data transaction.
    tick();
    if_req = 1'b1; if_addr = 32'h24; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    ack_wait = 0; n0 = cyc;
    #1;
    check("c_first_dm_gnt", dm_gnt, d_first);
    check("c_first_if_gnt", if_gnt, !d_first);
    check("c_first_stall_if", stall_if, d_first);
    check("c_first_stall_mem", stall_mem, !d_first);
    if (d_first) dm_q.push_back('{32'hCAFE_F00D, 1'b0, n0 + 2});
    else         if_q.push_back('{32'h0001_2345, 1'b0, n0 + 2});
    tick();
    if (d_first) dm_req = 1'b0;
    else         if_req = 1'b0;
    #1;
    check("c_busy_if_gnt", if_gnt, 0);
    check("c_busy_dm_gnt", dm_gnt, 0);
    check("c_busy_stall_if", stall_if, 1);
    check("c_busy_stall_mem", stall_mem, 1);
    tick(); #1;
    check("c_second_if_gnt", if_gnt, d_first);
    check("c_second_dm_gnt", dm_gnt, !d_first);
    check("c_second_stall_if", stall_if, 0);
    check("c_second_stall_mem", stall_mem, 0);
    if (d_first) if_q.push_back('{32'h0001_2345, 1'b0, n0 + 4});
    else         dm_q.push_back('{32'hCAFE_F00D, 1'b0, n0 + 4});
    tick();
    if_req = 1'b0; dm_req = 1'b0;
    drain(10);

    // Reset asserted mid-transaction. There must never be an rvalid for it.
    tick();
    dm_req = 1'b1; dm_addr = 32'h300; ack_wait = NEVER;
    #1;
    check("r_dm_gnt", dm_gnt, 1);
    tick();
    dm_req = 1'b0;
    tick();
    #1;
    check("r_mem_req_busy", mem_req, 1);
    tick();
    reset = 1'b0;
    #1;
    check("r_mem_req_reset", mem_req, 0);
    check("r_stall_mem_reset", stall_mem, 0);
    check("r_dm_rvalid_reset", dm_rvalid, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h10; ack_wait = 0; n0 = cyc;
    #1;
    check("r_if_gnt_fresh", if_gnt, 1);
    if_q.push_back('{32'h0050_0093, 1'b0, n0 + 2});
    tick();
    if_req = 1'b0;
    drain(10);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the Fetch stage (instruction reads) and the Memory stage (data loads/stores).
- Runs one outstanding transaction at a time and uses a 3-state FSM to sequence the memory handshake.
- Returns read data or write completion to the requester that owns the transaction.
- Drives per-stage stall requests that the hazard unit ORs into its StallF/StallD and pipeline-freeze logic.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 bits)
- TIMEOUT, 15, max cycles mem_req may wait for mem_ack before the transaction is aborted with an error

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  instruction read request (valid)
- if_addr  in  AW  instruction address
- if_gnt  out  1  instruction request accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DW  instruction word
- dm_req  in  1  data request (valid)
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_be  in  DW/8  store byte enables
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  one-cycle pulse: load data valid or store done
- dm_rdata  out  DW  load data (0 for stores)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_be  out  DW/8  memory byte enables
- mem_ack  in  1  memory completes the transaction this cycle; mem_rdata valid
- mem_rdata  in  DW  memory read data
- bus_err  out  1  one-cycle pulse with the rvalid of a timed-out transaction
- stall_if  out  1  fetch must hold
- stall_mem  out  1  memory stage must hold

Behaviour:
- Reset (async, active-low):
  - FSM goes to IDLE.
  - All outputs go to 0: gnt, rvalid, rdata, mem_*, bus_err, stall_*.
  - Pending flags and the timeout counter clear.
  - Reset asserted mid-transaction drops mem_req immediately. No rvalid is ever produced for the aborted transaction.
- Requester handshake:
  - The requester drives req with a stable payload.
  - gnt is combinational and asserts only in the acceptance cycle. The requester drops req, or presents a new request, in the following cycle.
  - The requester then waits for its rvalid.
- FSM states: IDLE, BUSY_I, BUSY_D.
  - IDLE: arbitrate.
    - dm_req set: assert dm_gnt, latch the payload, go to BUSY_D. dm_req wins over if_req (fixed priority, see Optional Feature).
    - Else if_req set: assert if_gnt, latch the address with we=0, go to BUSY_I.
  - BUSY_x: mem_req=1 with the latched payload. The payload is stable every cycle until ack.
    - mem_ack sampled high in cycle M: register mem_rdata (or 0 for a store) into x_rdata, pulse x_rvalid in cycle M+1, drop mem_req in M+1, return to IDLE in M+1.
    - A new request may be accepted in cycle M+1.
    - Latency, acceptance in cycle N to rvalid: ack-wait + 2 cycles. mem_req first rises in N+1. A zero-wait memory (ack in N+1) gives rvalid in N+2.
- No grant is issued outside IDLE. Requests arriving while BUSY wait in place.
- Timeout:
  - The counter resets on entry to BUSY and increments each cycle mem_ack=0.
  - When the count reaches TIMEOUT, the transaction completes as if acked: rvalid pulses, rdata=0, bus_err=1 in the same cycle, FSM returns to IDLE.
  - A mem_ack that arrives in the same cycle the count reaches TIMEOUT takes precedence as a normal completion.
- stall_if = (if_req & ~if_gnt) | if_pending. stall_mem = (dm_req & ~dm_gnt) | dm_pending.
  - x_pending sets on x_gnt and clears in the x_rvalid cycle.
  - So stall_x drops in the same cycle as x_rvalid.
- Simultaneous if_req and dm_req in IDLE: data is served first. if_req stays stalled and is granted in the IDLE cycle right after dm_rvalid, unless dm_req is asserted again.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - A 1-bit last-owner register (reset value: data) switches arbitration to round-robin.
  - On simultaneous requests in IDLE, the grant goes to the requester that did not own the previous transaction.
  - A lone request is always granted.
- Undefined: fixed data-over-instruction priority; no last-owner register.

Test Plan:
- Single fetch: if_req, if_addr=0x0000_0010; memory acks 2 cycles after mem_req rises with rdata=0x0050_0093 -> if_gnt in cycle 0, mem_req cycles 1–3, if_rvalid in cycle 4 with if_rdata=0x0050_0093, stall_if low from cycle 4.
- Store: dm_req, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_be=0xF, zero-wait ack -> mem_we=1, mem_be=0xF, mem_addr=0x100, mem_wdata=0xDEADBEEF for exactly one cycle; dm_rvalid with dm_rdata=0 two cycles after dm_gnt.
- Contention: if_req and dm_req both high in IDLE, zero-wait ack -> dm_gnt first; if_gnt in the cycle of dm_rvalid+0 (IDLE); stall_if high throughout. With ARB_RR_EN after a prior data transaction -> if_gnt first.
- Timeout: dm_req load, mem_ack held 0 -> after TIMEOUT=15 waiting cycles, dm_rvalid=1, bus_err=1, dm_rdata=0, mem_req drops, next request granted.
- Reset mid-operation: assert reset (low) while in BUSY_D -> mem_req 0 immediately, no dm_rvalid; after release a fresh if_req is granted in its first cycle.
